operand_fetch: RTL

//  Read-side client of the 32x32 register file: accepts decoded instructions (rs1, rs2, rd),

---
 rtl/opfetch_pkg.sv | 29 ++
 rtl/reg_scoreboard.sv | 59 +++++
 rtl/operand_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/opfetch_pkg.sv
// Shared definitions for the operand-fetch slice.
//   DW_DEF / AW_DEF : default data and register-index widths
//   REG_ZERO        : index of the hard-wired zero register
//   src_sel_e       : where an operand is taken from
//   pick_src        : source selection for one operand
package opfetch_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_RF     = 2'd2
  } src_sel_e;

  // r0 takes priority over a bypass hit so a writeback to r0 never leaks through.
  function automatic src_sel_e pick_src(input logic is_zero, input logic wb_hit);
    if (is_zero) begin
      return SRC_ZERO;
    end else if (wb_hit) begin
      return SRC_BYPASS;
    end else begin
      return SRC_RF;
    end
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
//   clk, rst            : clock, async active-high reset (clears all bits)
//   i_clr, i_clr_idx    : writeback retires the pending write to i_clr_idx
//   i_set, i_set_idx    : an accepted instruction will write i_set_idx
//   i_rs1, i_rs2, i_rd  : lookup indices
//   o_pend_rs1/rs2/rd   : pending state of each lookup index, already
//                         discounting a same-cycle clear of that index
module reg_scoreboard
  import opfetch_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic [AW-1:0] i_clr_idx,
  input  logic          i_set,
  input  logic [AW-1:0] i_set_idx,
  input  logic [AW-1:0] i_rs1,
  input  logic [AW-1:0] i_rs2,
  input  logic [AW-1:0] i_rd,
  output logic          o_pend_rs1,
  output logic          o_pend_rs2,
  output logic          o_pend_rd
);

  localparam int unsigned NREG = 2 ** AW;

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;

  // Clear first, then set: a new writer issued in the same cycle as the
  // retiring write to the same index keeps the bit set.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr) begin
      w_pend_nxt[i_clr_idx] = 1'b0;
    end
    if (i_set && (i_set_idx != AW'(REG_ZERO))) begin
      w_pend_nxt[i_set_idx] = 1'b1;
    end
    w_pend_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  always_comb begin
    o_pend_rs1 = r_pend[i_rs1] && !(i_clr && (i_clr_idx == i_rs1));
    o_pend_rs2 = r_pend[i_rs2] && !(i_clr && (i_clr_idx == i_rs2));
    o_pend_rd  = r_pend[i_rd]  && !(i_clr && (i_clr_idx == i_rd));
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage between decode and execute.
//   in_*      : decoded instruction handshake (rs1, rs2, rd, wr_en)
//   sel_o1/2  : register-file read selects (combinational from in_rs1/2)
//   Op1/Op2   : register-file read data
//   wb_*      : snooped register-file write port
//   out_*     : registered operands + rd/wr_en to execute (1-cycle latency)
// RAW/WAW hazards against pending writes stall in_ready; a writeback in the
// same cycle resolves the hazard and is bypassed into the operand.
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          in_wr_en,
  output logic [AW-1:0] sel_o1,
  output logic [AW-1:0] sel_o2,
  input  logic [DW-1:0] Op1,
  input  logic [DW-1:0] Op2,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_sel,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [AW-1:0] out_rd,
  output logic          out_wr_en
);

  logic          w_pend_rs1;
  logic          w_pend_rs2;
  logic          w_pend_rd;
  logic          w_rd_nonzero;
  logic          w_hazard;
  logic          w_accept;
  src_sel_e      w_src1;
  src_sel_e      w_src2;
  logic [DW-1:0] w_opa;
  logic [DW-1:0] w_opb;

  logic          r_valid;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [AW-1:0] r_rd;
  logic          r_wr_en;

  reg_scoreboard #(
    .AW (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (wb_valid),
    .i_clr_idx  (wb_sel),
    .i_set      (w_accept && in_wr_en),
    .i_set_idx  (in_rd),
    .i_rs1      (in_rs1),
    .i_rs2      (in_rs2),
    .i_rd       (in_rd),
    .o_pend_rs1 (w_pend_rs1),
    .o_pend_rs2 (w_pend_rs2),
    .o_pend_rd  (w_pend_rd)
  );

  assign sel_o1 = in_rs1;
  assign sel_o2 = in_rs2;

  always_comb begin
    w_rd_nonzero = (in_rd != AW'(REG_ZERO));
    w_hazard     = in_valid && (w_pend_rs1 || w_pend_rs2
                                || (in_wr_en && w_rd_nonzero && w_pend_rd));
    in_ready     = !w_hazard && (!r_valid || out_ready);
    w_accept     = in_valid && in_ready;
  end

  always_comb begin
    w_src1 = pick_src(in_rs1 == AW'(REG_ZERO), wb_valid && (wb_sel == in_rs1));
    w_src2 = pick_src(in_rs2 == AW'(REG_ZERO), wb_valid && (wb_sel == in_rs2));
    w_opa  = '0;
    w_opb  = '0;
    case (w_src1)
      SRC_BYPASS: w_opa = wb_data;
      SRC_RF:     w_opa = Op1;
      default:    w_opa = '0;
    endcase
    case (w_src2)
      SRC_BYPASS: w_opb = wb_data;
      SRC_RF:     w_opb = Op2;
      default:    w_opb = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_rd    <= '0;
      r_wr_en <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_a     <= w_opa;
      r_b     <= w_opb;
      r_rd    <= in_rd;
      r_wr_en <= in_wr_en;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_rd    = r_rd;
  assign out_wr_en = r_wr_en;

endmodule
